mul_combine: RTL and testbench

MUL_COMBINE -- requirements
Module: mul_combine

---
 rtl/mul_combine_if.sv | 35 +++
 rtl/mul_combine.sv | 151 +++++++++++++++
 tb/tb_mul_combine.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_combine_if.sv
// rtl/mul_combine_if.sv - partial-product request and combined-result signals for mul_combine
interface mul_combine_if;
   logic        M_en;
   logic        M_flush;
   logic        M_mul_valid;
   logic [31:0] M_mul_cell_p1;
   logic [31:0] M_mul_cell_p2;
   logic [31:0] M_mul_cell_p3;
   logic [31:0] M_mul_cell_p4;
   logic        M_ctrl_mul_src1_signed;
   logic        M_ctrl_mul_src2_signed;
   logic        M_ctrl_mul_hi;
   logic [4:0]  M_dst_regnum;
   logic [31:0] A_mul_result;
   logic        A_mul_valid;
   logic [4:0]  A_dst_regnum;

   // Requesting side: drives the partial products, observes the result.
   modport master (
      output M_en, M_flush, M_mul_valid,
      output M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3, M_mul_cell_p4,
      output M_ctrl_mul_src1_signed, M_ctrl_mul_src2_signed, M_ctrl_mul_hi,
      output M_dst_regnum,
      input  A_mul_result, A_mul_valid, A_dst_regnum
   );

   // Combiner side.
   modport slave (
      input  M_en, M_flush, M_mul_valid,
      input  M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3, M_mul_cell_p4,
      input  M_ctrl_mul_src1_signed, M_ctrl_mul_src2_signed, M_ctrl_mul_hi,
      input  M_dst_regnum,
      output A_mul_result, A_mul_valid, A_dst_regnum
   );
endinterface

// File: rtl/mul_combine.sv
// rtl/mul_combine.sv - combines four 16x16 partial products into a 32-bit product word; MUL_COMBINE_OUT_REG_EN adds an output register stage
module mul_combine #(
   parameter int CLEAR_INVALID = 1
) (
   input  logic          clk,
   input  logic          reset,
   mul_combine_if.slave  bus
);

   // Stage 1: cross terms summed, outer terms carried.
   logic        r_s1_valid;
   logic [33:0] r_s1_mid;
   logic [31:0] r_s1_p1;
   logic [31:0] r_s1_p4;
   logic        r_s1_hi;
   logic [4:0]  r_s1_tag;

   // Stage 2: selected product word.
   logic        r_s2_valid;
   logic [31:0] r_s2_word;
   logic [4:0]  r_s2_tag;

   logic [33:0] w_ext_p2;
   logic [33:0] w_ext_p3;
   logic [33:0] w_mid;
   logic [63:0] w_mid_shifted;
   logic [63:0] w_prod64;
   logic [31:0] w_sel_word;

   logic        w_out_valid;
   logic [31:0] w_out_word;
   logic [4:0]  w_out_tag;
   logic [31:0] w_out_result;

   // p2 carries the src2 high half and p3 the src1 high half, so each
   // follows the signedness of the operand its high half came from.
   always_comb begin
      w_ext_p2 = bus.M_ctrl_mul_src2_signed ? {{2{bus.M_mul_cell_p2[31]}}, bus.M_mul_cell_p2}
                                            : {2'b00, bus.M_mul_cell_p2};
      w_ext_p3 = bus.M_ctrl_mul_src1_signed ? {{2{bus.M_mul_cell_p3[31]}}, bus.M_mul_cell_p3}
                                            : {2'b00, bus.M_mul_cell_p3};
      w_mid    = w_ext_p2 + w_ext_p3;
   end

   // Stage 1 valid: flush kills the incoming op even when enabled.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
      end else if (bus.M_flush) begin
         r_s1_valid <= 1'b0;
      end else if (bus.M_en) begin
         r_s1_valid <= bus.M_mul_valid;
      end
   end

   // Stage 1 data and tag: loaded on every enabled cycle, untouched by flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_mid <= '0;
         r_s1_p1  <= '0;
         r_s1_p4  <= '0;
         r_s1_hi  <= 1'b0;
         r_s1_tag <= '0;
      end else if (bus.M_en) begin
         r_s1_mid <= w_mid;
         r_s1_p1  <= bus.M_mul_cell_p1;
         r_s1_p4  <= bus.M_mul_cell_p4;
         r_s1_hi  <= bus.M_ctrl_mul_hi;
         r_s1_tag <= bus.M_dst_regnum;
      end
   end

   // The middle sum is signed at 34 bits; extending it to 64 lets a negative
   // cross term borrow from the high word, with the final add wrapping mod 2^64.
   always_comb begin
      w_mid_shifted = {{30{r_s1_mid[33]}}, r_s1_mid} << 16;
      w_prod64      = {r_s1_p4, r_s1_p1} + w_mid_shifted;
      w_sel_word    = r_s1_hi ? w_prod64[63:32] : w_prod64[31:0];
   end

   // Stage 2 valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s2_valid <= 1'b0;
      end else if (bus.M_flush) begin
         r_s2_valid <= 1'b0;
      end else if (bus.M_en) begin
         r_s2_valid <= r_s1_valid;
      end
   end

   // Stage 2 word and tag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s2_word <= '0;
         r_s2_tag  <= '0;
      end else if (bus.M_en) begin
         r_s2_word <= w_sel_word;
         r_s2_tag  <= r_s1_tag;
      end
   end

`ifdef MUL_COMBINE_OUT_REG_EN
   logic        r_s3_valid;
   logic [31:0] r_s3_word;
   logic [4:0]  r_s3_tag;

   // Output stage valid, same hold/flush/reset behaviour as the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s3_valid <= 1'b0;
      end else if (bus.M_flush) begin
         r_s3_valid <= 1'b0;
      end else if (bus.M_en) begin
         r_s3_valid <= r_s2_valid;
      end
   end

   // Output stage word and tag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s3_word <= '0;
         r_s3_tag  <= '0;
      end else if (bus.M_en) begin
         r_s3_word <= r_s2_word;
         r_s3_tag  <= r_s2_tag;
      end
   end

   assign w_out_valid = r_s3_valid;
   assign w_out_word  = r_s3_word;
   assign w_out_tag   = r_s3_tag;
`else
   assign w_out_valid = r_s2_valid;
   assign w_out_word  = r_s2_word;
   assign w_out_tag   = r_s2_tag;
`endif

   // Optionally hide stale data behind an invalid flag.
   always_comb begin
      w_out_result = w_out_word;
      if ((CLEAR_INVALID != 0) && !w_out_valid) begin
         w_out_result = '0;
      end
   end

   assign bus.A_mul_result = w_out_result;
   assign bus.A_mul_valid  = w_out_valid;
   assign bus.A_dst_regnum = w_out_tag;

endmodule

// File: tb/tb_mul_combine.sv
// tb/tb_mul_combine.sv - directed self-checking bench for mul_combine
module tb_mul_combine;

`ifdef MUL_COMBINE_OUT_REG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif
   localparam int N = 8;

   logic clk = 1'b0;
   logic reset;
   int   n_pass = 0;
   int   n_total = 0;

   logic [31:0] t_p1 [N];
   logic [31:0] t_p2 [N];
   logic [31:0] t_p3 [N];
   logic [31:0] t_p4 [N];
   logic        t_s1 [N];
   logic        t_s2 [N];
   logic        t_hi [N];
   logic [4:0]  t_tag[N];
   logic [31:0] t_exp[N];

   mul_combine_if bus ();

   mul_combine #(.CLEAR_INVALID(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input int k);
      bus.M_mul_valid            = 1'b1;
      bus.M_mul_cell_p1          = t_p1[k];
      bus.M_mul_cell_p2          = t_p2[k];
      bus.M_mul_cell_p3          = t_p3[k];
      bus.M_mul_cell_p4          = t_p4[k];
      bus.M_ctrl_mul_src1_signed = t_s1[k];
      bus.M_ctrl_mul_src2_signed = t_s2[k];
      bus.M_ctrl_mul_hi          = t_hi[k];
      bus.M_dst_regnum           = t_tag[k];
   endtask

   task automatic drive_junk();
      bus.M_mul_valid   = 1'b1;
      bus.M_mul_cell_p1 = 32'h1234_5678;
      bus.M_mul_cell_p2 = 32'h9ABC_DEF0;
      bus.M_mul_cell_p3 = 32'h0F0F_0F0F;
      bus.M_mul_cell_p4 = 32'hF0F0_F0F0;
      bus.M_dst_regnum  = 5'd31;
   endtask

   task automatic load_table();
      // 0x00010002 x 0x00030004 unsigned
      t_p1[0] = 32'd8; t_p2[0] = 32'd6; t_p3[0] = 32'd4; t_p4[0] = 32'd3;
      t_s1[0] = 1'b0; t_s2[0] = 1'b0; t_hi[0] = 1'b0; t_tag[0] = 5'd1; t_exp[0] = 32'h000A_0008;
      t_p1[1] = 32'd8; t_p2[1] = 32'd6; t_p3[1] = 32'd4; t_p4[1] = 32'd3;
      t_s1[1] = 1'b0; t_s2[1] = 1'b0; t_hi[1] = 1'b1; t_tag[1] = 5'd2; t_exp[1] = 32'h0000_0003;
      // -1 x -1 signed: lo halves 0xFFFF, hi halves -1
      t_p1[2] = 32'hFFFE_0001; t_p2[2] = 32'hFFFF_0001; t_p3[2] = 32'hFFFF_0001; t_p4[2] = 32'd1;
      t_s1[2] = 1'b1; t_s2[2] = 1'b1; t_hi[2] = 1'b0; t_tag[2] = 5'd3; t_exp[2] = 32'h0000_0001;
      t_p1[3] = 32'hFFFE_0001; t_p2[3] = 32'hFFFF_0001; t_p3[3] = 32'hFFFF_0001; t_p4[3] = 32'd1;
      t_s1[3] = 1'b1; t_s2[3] = 1'b1; t_hi[3] = 1'b1; t_tag[3] = 5'd4; t_exp[3] = 32'h0000_0000;
      // 0xFFFFFFFF squared unsigned
      t_p1[4] = 32'hFFFE_0001; t_p2[4] = 32'hFFFE_0001; t_p3[4] = 32'hFFFE_0001; t_p4[4] = 32'hFFFE_0001;
      t_s1[4] = 1'b0; t_s2[4] = 1'b0; t_hi[4] = 1'b1; t_tag[4] = 5'd5; t_exp[4] = 32'hFFFF_FFFE;
      t_p1[5] = 32'hFFFE_0001; t_p2[5] = 32'hFFFE_0001; t_p3[5] = 32'hFFFE_0001; t_p4[5] = 32'hFFFE_0001;
      t_s1[5] = 1'b0; t_s2[5] = 1'b0; t_hi[5] = 1'b0; t_tag[5] = 5'd6; t_exp[5] = 32'h0000_0001;
      // signed -1 x unsigned 1 = -1: only p3 (src1 hi x src2 lo) is negative
      t_p1[6] = 32'h0000_FFFF; t_p2[6] = 32'd0; t_p3[6] = 32'hFFFF_FFFF; t_p4[6] = 32'd0;
      t_s1[6] = 1'b1; t_s2[6] = 1'b0; t_hi[6] = 1'b1; t_tag[6] = 5'd7; t_exp[6] = 32'hFFFF_FFFF;
      t_p1[7] = 32'h0000_FFFF; t_p2[7] = 32'd0; t_p3[7] = 32'hFFFF_FFFF; t_p4[7] = 32'd0;
      t_s1[7] = 1'b1; t_s2[7] = 1'b0; t_hi[7] = 1'b0; t_tag[7] = 5'd8; t_exp[7] = 32'hFFFF_FFFF;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.M_en = 1'b0;
      drive_junk();
      tick();
      tick();
      n_total++;
      if (bus.A_mul_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.A_mul_valid);
      else n_pass++;
      n_total++;
      if (bus.A_mul_result !== 32'd0) $display("FAIL reset_result: got %h want 00000000", bus.A_mul_result);
      else n_pass++;
      n_total++;
      if (bus.A_dst_regnum !== 5'd0) $display("FAIL reset_tag: got %0d want 0", bus.A_dst_regnum);
      else n_pass++;
      reset = 1'b0;
      bus.M_en = 1'b1;
      bus.M_mul_valid = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < N + LAT - 1; i++) begin
         if (i < N) drive_op(i);
         else bus.M_mul_valid = 1'b0;
         tick();
         if (i >= LAT - 1) begin
            n_total++;
            if (bus.A_mul_valid !== 1'b1 || bus.A_mul_result !== t_exp[i-LAT+1] ||
                bus.A_dst_regnum !== t_tag[i-LAT+1])
               $display("FAIL b2b_op%0d: got v=%b r=%h t=%0d want v=1 r=%h t=%0d", i - LAT + 1,
                        bus.A_mul_valid, bus.A_mul_result, bus.A_dst_regnum,
                        t_exp[i-LAT+1], t_tag[i-LAT+1]);
            else n_pass++;
         end else begin
            n_total++;
            if (bus.A_mul_valid !== 1'b0 || bus.A_mul_result !== 32'd0)
               $display("FAIL b2b_fill%0d: got v=%b r=%h want v=0 r=00000000", i,
                        bus.A_mul_valid, bus.A_mul_result);
            else n_pass++;
         end
      end
      tick();
      n_total++;
      if (bus.A_mul_valid !== 1'b0 || bus.A_mul_result !== 32'd0)
         $display("FAIL b2b_drain: got v=%b r=%h want v=0 r=00000000", bus.A_mul_valid, bus.A_mul_result);
      else n_pass++;
      repeat (LAT) tick();
   endtask

   task automatic test_stall();
      drive_op(0);
      bus.M_dst_regnum = 5'd9;
      tick();
      bus.M_en = 1'b0;
      drive_junk();
      for (int i = 0; i < 3; i++) begin
         tick();
         n_total++;
         if (bus.A_mul_valid !== 1'b0 || bus.A_mul_result !== 32'd0)
            $display("FAIL stall_hold%0d: got v=%b r=%h want v=0 r=00000000", i,
                     bus.A_mul_valid, bus.A_mul_result);
         else n_pass++;
      end
      bus.M_en = 1'b1;
      bus.M_mul_valid = 1'b0;
      repeat (LAT - 2) tick();
      n_total++;
      if (bus.A_mul_valid !== 1'b0)
         $display("FAIL stall_early: got v=%b want 0", bus.A_mul_valid);
      else n_pass++;
      tick();
      n_total++;
      if (bus.A_mul_valid !== 1'b1 || bus.A_mul_result !== 32'h000A_0008 || bus.A_dst_regnum !== 5'd9)
         $display("FAIL stall_resume: got v=%b r=%h t=%0d want v=1 r=000a0008 t=9",
                  bus.A_mul_valid, bus.A_mul_result, bus.A_dst_regnum);
      else n_pass++;
      bus.M_en = 1'b0;
      drive_junk();
      repeat (2) tick();
      n_total++;
      if (bus.A_mul_valid !== 1'b1 || bus.A_mul_result !== 32'h000A_0008 || bus.A_dst_regnum !== 5'd9)
         $display("FAIL stall_out_stable: got v=%b r=%h t=%0d want v=1 r=000a0008 t=9",
                  bus.A_mul_valid, bus.A_mul_result, bus.A_dst_regnum);
      else n_pass++;
      bus.M_en = 1'b1;
      bus.M_mul_valid = 1'b0;
      repeat (LAT) tick();
   endtask

   task automatic test_flush();
      drive_op(0);
      bus.M_dst_regnum = 5'd10;
      tick();
      drive_op(1);
      bus.M_dst_regnum = 5'd11;
      bus.M_flush = 1'b1;
      tick();
      bus.M_flush = 1'b0;
      bus.M_mul_valid = 1'b0;
      repeat (LAT - 2) tick();
      n_total++;
      if (bus.A_mul_valid !== 1'b0 || bus.A_mul_result !== 32'd0 || bus.A_dst_regnum !== 5'd10)
         $display("FAIL flush_tag_kept: got v=%b r=%h t=%0d want v=0 r=00000000 t=10",
                  bus.A_mul_valid, bus.A_mul_result, bus.A_dst_regnum);
      else n_pass++;
      for (int i = 0; i < LAT + 1; i++) begin
         tick();
         n_total++;
         if (bus.A_mul_valid !== 1'b0 || bus.A_mul_result !== 32'd0)
            $display("FAIL flush_dead%0d: got v=%b r=%h want v=0 r=00000000", i,
                     bus.A_mul_valid, bus.A_mul_result);
         else n_pass++;
      end
      // flush while stalled still kills the op
      drive_op(2);
      tick();
      bus.M_mul_valid = 1'b0;
      bus.M_en = 1'b0;
      bus.M_flush = 1'b1;
      tick();
      bus.M_flush = 1'b0;
      bus.M_en = 1'b1;
      for (int i = 0; i < LAT; i++) begin
         tick();
         n_total++;
         if (bus.A_mul_valid !== 1'b0)
            $display("FAIL flush_stalled%0d: got v=%b want 0", i, bus.A_mul_valid);
         else n_pass++;
      end
   endtask

   task automatic test_reset_midpipe();
      drive_op(4);
      bus.M_dst_regnum = 5'd12;
      tick();
      drive_op(5);
      bus.M_dst_regnum = 5'd13;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.M_mul_valid = 1'b0;
      n_total++;
      if (bus.A_mul_valid !== 1'b0 || bus.A_mul_result !== 32'd0 || bus.A_dst_regnum !== 5'd0)
         $display("FAIL rst_mid: got v=%b r=%h t=%0d want v=0 r=00000000 t=0",
                  bus.A_mul_valid, bus.A_mul_result, bus.A_dst_regnum);
      else n_pass++;
      for (int i = 0; i < LAT; i++) begin
         tick();
         n_total++;
         if (bus.A_mul_valid !== 1'b0)
            $display("FAIL rst_dead%0d: got v=%b want 0", i, bus.A_mul_valid);
         else n_pass++;
      end
      drive_op(2);
      bus.M_dst_regnum = 5'd14;
      tick();
      bus.M_mul_valid = 1'b0;
      repeat (LAT - 2) tick();
      n_total++;
      if (bus.A_mul_valid !== 1'b0)
         $display("FAIL rst_new_early: got v=%b want 0", bus.A_mul_valid);
      else n_pass++;
      tick();
      n_total++;
      if (bus.A_mul_valid !== 1'b1 || bus.A_mul_result !== 32'h0000_0001 || bus.A_dst_regnum !== 5'd14)
         $display("FAIL rst_new_op: got v=%b r=%h t=%0d want v=1 r=00000001 t=14",
                  bus.A_mul_valid, bus.A_mul_result, bus.A_dst_regnum);
      else n_pass++;
   endtask

   initial begin
      reset = 1'b1;
      bus.M_en = 1'b0;
      bus.M_flush = 1'b0;
      bus.M_mul_valid = 1'b0;
      bus.M_mul_cell_p1 = '0;
      bus.M_mul_cell_p2 = '0;
      bus.M_mul_cell_p3 = '0;
      bus.M_mul_cell_p4 = '0;
      bus.M_ctrl_mul_src1_signed = 1'b0;
      bus.M_ctrl_mul_src2_signed = 1'b0;
      bus.M_ctrl_mul_hi = 1'b0;
      bus.M_dst_regnum = '0;
      load_table();
      test_reset();
      test_back_to_back();
      test_stall();
      test_flush();
      test_reset_midpipe();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
